// File: rtl/approx_operand_normalizer.sv
// Operand normaliser for the approximate multiplier: left-justifies two unsigned
// operands one bit per cycle and hands the top mantissa bits plus shift counts downstream.
module approx_operand_normalizer #(
   parameter int IN_W   = 16,
   parameter int MANT_W = 8,
   parameter int SH_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [IN_W-1:0]   a_in,
   input  logic [IN_W-1:0]   b_in,
   output logic              busy,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [MANT_W-1:0] a_mant,
   output logic [MANT_W-1:0] b_mant,
   output logic [SH_W-1:0]   a_shift,
   output logic [SH_W-1:0]   b_shift,
   output logic [SH_W:0]     total_shift,
   output logic              zero_op
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] NORM_A = 2'd1;
   localparam logic [1:0] NORM_B = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   logic [1:0]      state;
   logic [IN_W-1:0] reg_a, reg_b;
   logic [SH_W-1:0] cnt_a, cnt_b;
   logic            zero_flag;

   // A zero operand exits immediately so the counters can never wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         reg_a     <= '0;
         reg_b     <= '0;
         cnt_a     <= '0;
         cnt_b     <= '0;
         zero_flag <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  reg_a     <= a_in;
                  reg_b     <= b_in;
                  cnt_a     <= '0;
                  cnt_b     <= '0;
                  zero_flag <= 1'b0;
                  state     <= NORM_A;
               end
            end
            NORM_A: begin
               if (reg_a[IN_W-1] || reg_a == '0) begin
                  if (reg_a == '0) zero_flag <= 1'b1;
                  state <= NORM_B;
               end else begin
                  reg_a <= {reg_a[IN_W-2:0], 1'b0};
                  cnt_a <= cnt_a + 1'b1;
               end
            end
            NORM_B: begin
               if (reg_b[IN_W-1] || reg_b == '0) begin
                  if (reg_b == '0) zero_flag <= 1'b1;
                  state <= DONE;
               end else begin
                  reg_b <= {reg_b[IN_W-2:0], 1'b0};
                  cnt_b <= cnt_b + 1'b1;
               end
            end
            default: begin
               if (out_ready) state <= IDLE;
            end
         endcase
      end
   end

   // Outputs depend only on registered state, never directly on start/out_ready.
   assign busy        = (state != IDLE);
   assign out_valid   = (state == DONE);
   assign a_mant      = reg_a[IN_W-1 -: MANT_W];
   assign b_mant      = reg_b[IN_W-1 -: MANT_W];
   assign a_shift     = cnt_a;
   assign b_shift     = cnt_b;
   assign total_shift = {1'b0, cnt_a} + {1'b0, cnt_b};
   assign zero_op     = zero_flag;

endmodule

// File: tb/tb_approx_operand_normalizer.sv
// Self-checking bench for approx_operand_normalizer: directed and random operands
// against a leading-one reference model, including reset abort and backpressure.
module tb_approx_operand_normalizer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] a_in, b_in;
   logic        busy, out_valid, out_ready;
   logic [7:0]  a_mant, b_mant;
   logic [3:0]  a_shift, b_shift;
   logic [4:0]  total_shift;
   logic        zero_op;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   approx_operand_normalizer dut (
      .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
      .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
      .a_mant(a_mant), .b_mant(b_mant), .a_shift(a_shift), .b_shift(b_shift),
      .total_shift(total_shift), .zero_op(zero_op)
   );

   // Reference: shift = distance of the leading one from bit 15; mantissa = top byte after shifting.
   function automatic void model(input logic [15:0] x, output int m, output int s);
      int hi;
      hi = -1;
      for (int i = 0; i < 16; i++) if (x[i]) hi = i;
      if (hi < 0) begin
         s = 0; m = 0;
      end else begin
         s = 15 - hi;
         m = ((int'(x) << s) >> 8) & 255;
      end
   endfunction

   // Issues one operation and checks latency and results; with out_ready=0 it returns while in DONE.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input string name);
      int em_a, es_a, em_b, es_b, lat, ez;
      model(a, em_a, es_a);
      model(b, em_b, es_b);
      ez = (a == 0 || b == 0) ? 1 : 0;
      @(negedge clk);
      a_in = a; b_in = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      total++; if (lat !== es_a + es_b + 2) $display("FAIL %s latency: got %0d expected %0d", name, lat, es_a + es_b + 2); else passed++;
      total++; if (a_mant !== 8'(em_a)) $display("FAIL %s a_mant: got %h expected %h", name, a_mant, em_a); else passed++;
      total++; if (b_mant !== 8'(em_b)) $display("FAIL %s b_mant: got %h expected %h", name, b_mant, em_b); else passed++;
      total++; if (a_shift !== 4'(es_a)) $display("FAIL %s a_shift: got %0d expected %0d", name, a_shift, es_a); else passed++;
      total++; if (b_shift !== 4'(es_b)) $display("FAIL %s b_shift: got %0d expected %0d", name, b_shift, es_b); else passed++;
      total++; if (total_shift !== 5'(es_a + es_b)) $display("FAIL %s total_shift: got %0d expected %0d", name, total_shift, es_a + es_b); else passed++;
      total++; if (zero_op !== 1'(ez)) $display("FAIL %s zero_op: got %b expected %0d", name, zero_op, ez); else passed++;
      total++; if (busy !== 1'b1) $display("FAIL %s busy_in_done: got %b expected 1", name, busy); else passed++;
      if (out_ready) begin
         @(posedge clk); #1;
         total++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL %s post_handshake: got valid=%b busy=%b expected 0/0", name, out_valid, busy); else passed++;
         total++; if (a_mant !== 8'(em_a) || b_mant !== 8'(em_b) || total_shift !== 5'(es_a + es_b)) $display("FAIL %s data_retained: got %h %h %0d expected %h %h %0d", name, a_mant, b_mant, total_shift, em_a, em_b, es_a + es_b); else passed++;
      end
   endtask

   task automatic test_reset();
      #1;
      total++; if ({busy, out_valid, a_mant, b_mant, a_shift, b_shift, total_shift, zero_op} !== '0) $display("FAIL reset_state: got busy=%b valid=%b am=%h bm=%h as=%0d bs=%0d ts=%0d z=%b expected all 0", busy, out_valid, a_mant, b_mant, a_shift, b_shift, total_shift, zero_op); else passed++;
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_reset_abort();
      @(negedge clk);
      a_in = 16'h0001; b_in = 16'h0001; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (3) @(posedge clk);
      #2; rst = 1'b1; #1;
      total++; if ({busy, out_valid, a_mant, b_mant, a_shift, b_shift, total_shift, zero_op} !== '0) $display("FAIL reset_abort: got busy=%b valid=%b am=%h bm=%h as=%0d bs=%0d ts=%0d z=%b expected all 0", busy, out_valid, a_mant, b_mant, a_shift, b_shift, total_shift, zero_op); else passed++;
      @(negedge clk); rst = 1'b0;
      run_op(16'h0001, 16'h0001, "after_abort");
   endtask

   task automatic test_directed();
      out_ready = 1'b1;
      run_op(16'h1234, 16'h0F0F, "mixed");
      run_op(16'h8000, 16'hFFFF, "no_shift");
      run_op(16'h0001, 16'h0001, "max_shift");
      run_op(16'h0000, 16'h00FF, "zero_a");
      run_op(16'hABCD, 16'h0000, "zero_b");
   endtask

   task automatic test_random();
      logic [15:0] a, b;
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         a = 16'($urandom) >> $urandom_range(0, 15);
         b = 16'($urandom) >> $urandom_range(0, 15);
         if ($urandom_range(0, 7) == 0) a = '0;
         run_op(a, b, "random");
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] am, bm;
      logic [4:0] ts;
      out_ready = 1'b0;
      run_op(16'h0300, 16'h4001, "bp");
      am = a_mant; bm = b_mant; ts = total_shift;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         start = ~start; a_in = 16'($urandom); b_in = 16'($urandom);
         @(posedge clk); #1;
         total++; if (out_valid !== 1'b1 || a_mant !== am || b_mant !== bm || total_shift !== ts) $display("FAIL bp_hold: got valid=%b %h %h %0d expected 1 %h %h %0d", out_valid, a_mant, b_mant, total_shift, am, bm, ts); else passed++;
      end
      @(negedge clk); start = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL bp_release: got valid=%b busy=%b expected 0/0", out_valid, busy); else passed++;
      run_op(16'h0010, 16'h2000, "bp_next");
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      run_op(16'h7FFF, 16'h0002, "b2b_0");
      run_op(16'h0C00, 16'h0000, "b2b_1");
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;
      test_reset();
      test_directed();
      test_reset_abort();
      test_random();
      test_backpressure();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
